// File: rtl/ucie_fifo_pkg.sv
// Shared Gray-code helpers for the async FIFO write and read pointer controllers.
// Functions work on a 32-bit container; callers zero-extend narrower pointers and keep the low bits.
package ucie_fifo_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   // Zero-extension keeps this exact for any pointer width up to GRAY_MAX_W.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin_v);
      return bin_v ^ (bin_v >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray_v);
      logic [GRAY_MAX_W-1:0] bin_v;
      bin_v[GRAY_MAX_W-1] = gray_v[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin_v[i] = bin_v[i+1] ^ gray_v[i];
      end
      return bin_v;
   endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// Shared between the write-side and read-side FIFO controllers.
module ptr_sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             w_clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] rq1_q;
   logic [WIDTH-1:0] rq2_q;

   // Metastability-settling flop chain; nothing else samples the raw input.
   always_ff @(posedge w_clk or negedge rst) begin
      if (!rst) begin
         rq1_q <= {WIDTH{1'b0}};
         rq2_q <= {WIDTH{1'b0}};
      end else begin
         rq1_q <= d;
         rq2_q <= rq1_q;
      end
   end

   assign q = rq2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: write pointer, Gray export, full/almost-full,
// free-slot count and sticky overflow, all computed against the synchronized read pointer.
module fifo_wr_ctrl
   import ucie_fifo_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int AF_THRESH  = 2,
   localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   localparam int PW         = ADDR_WIDTH + 1
) (
   input  logic                  w_clk,
   input  logic                  rst,
   input  logic                  w_inc,
   input  logic                  ovf_clr,
   input  logic [PW-1:0]         r_ptr_gray,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [PW-1:0]         w_ptr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [PW-1:0]         free_cnt,
   output logic                  overflow
);

   localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};
   localparam logic          AF_RST    = (AF_THRESH >= FIFO_DEPTH) ? 1'b1 : 1'b0;

   logic [PW-1:0] w_bin_q,  w_bin_d;
   logic [PW-1:0] w_gray_q, w_gray_d;
   logic [PW-1:0] free_q,   free_d;
   logic          full_q,   full_d;
   logic          af_q,     af_d;
   logic          ovf_q,    ovf_d;

   logic [PW-1:0]         rq2_s;
   logic [PW-1:0]         rbin_s;
   logic [PW-1:0]         used_s;
   logic                  w_en_s;
   logic [GRAY_MAX_W-1:0] gray_wide_s;
   logic [GRAY_MAX_W-1:0] rbin_wide_s;

   ptr_sync_2ff #(
      .WIDTH (PW)
   ) u_rptr_sync (
      .w_clk (w_clk),
      .rst   (rst),
      .d     (r_ptr_gray),
      .q     (rq2_s)
   );

   // Reset gating keeps the memory strobe quiet while the write view is being discarded.
   assign w_en_s   = w_inc & ~full_q & rst;
   assign w_bin_d  = w_bin_q + {{(PW-1){1'b0}}, w_en_s};

   assign gray_wide_s = bin2gray({{(GRAY_MAX_W-PW){1'b0}}, w_bin_d});
   assign rbin_wide_s = gray2bin({{(GRAY_MAX_W-PW){1'b0}}, rq2_s});
   assign w_gray_d    = gray_wide_s[PW-1:0];
   assign rbin_s      = rbin_wide_s[PW-1:0];

   // Modulo-2^PW subtraction makes the occupancy immune to pointer wrap.
   assign used_s = w_bin_d - rbin_s;
   assign free_d = DEPTH_P - used_s;
   assign full_d = (w_gray_d == (rq2_s ^ FULL_MASK));
   assign af_d   = (32'(free_d) <= 32'(AF_THRESH));

   // Sticky overflow: a new rejected write beats a concurrent clear.
   always_comb begin
      ovf_d = ovf_q;
      if (w_inc && full_q) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Pointer and flag state registers.
   always_ff @(posedge w_clk or negedge rst) begin
      if (!rst) begin
         w_bin_q  <= {PW{1'b0}};
         w_gray_q <= {PW{1'b0}};
         free_q   <= DEPTH_P;
         full_q   <= 1'b0;
         af_q     <= AF_RST;
         ovf_q    <= 1'b0;
      end else begin
         w_bin_q  <= w_bin_d;
         w_gray_q <= w_gray_d;
         free_q   <= free_d;
         full_q   <= full_d;
         af_q     <= af_d;
         ovf_q    <= ovf_d;
      end
   end

   assign w_en        = w_en_s;
   assign w_addr      = w_bin_q[ADDR_WIDTH-1:0];
   assign w_ptr_gray  = w_gray_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign free_cnt    = free_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (FIFO_DEPTH=8, AF_THRESH=2): vector table for fill,
// overflow, drain and re-fill, then hand sequences for mid-stream reset and pointer wrap.
module tb_fifo_wr_ctrl;

   logic       w_clk;
   logic       rst;
   logic       w_inc;
   logic       ovf_clr;
   logic [3:0] r_ptr_gray;
   logic       w_en;
   logic [2:0] w_addr;
   logic [3:0] w_ptr_gray;
   logic       full;
   logic       almost_full;
   logic [3:0] free_cnt;
   logic       overflow;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic       inc;
      logic       clr;
      logic [3:0] rg;
      logic       en;
      logic [2:0] addr;
      logic [3:0] gray;
      logic       full;
      logic       af;
      logic [3:0] free;
      logic       ovf;
   } vec_t;

   vec_t tbl [18];

   fifo_wr_ctrl #(
      .FIFO_DEPTH (8),
      .AF_THRESH  (2)
   ) dut (
      .w_clk       (w_clk),
      .rst         (rst),
      .w_inc       (w_inc),
      .ovf_clr     (ovf_clr),
      .r_ptr_gray  (r_ptr_gray),
      .w_en        (w_en),
      .w_addr      (w_addr),
      .w_ptr_gray  (w_ptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .free_cnt    (free_cnt),
      .overflow    (overflow)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] g4(input int x);
      logic [3:0] b;
      b = x[3:0];
      return b ^ (b >> 1);
   endfunction

   initial begin
      n_cmp = 0;
      n_bad = 0;
      //               inc   clr   rg    en    addr  gray   full  af    free  ovf
      tbl[0]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd0, 4'd1,  1'b0, 1'b0, 4'd7, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd1, 4'd3,  1'b0, 1'b0, 4'd6, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd2, 4'd2,  1'b0, 1'b0, 4'd5, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd3, 4'd6,  1'b0, 1'b0, 4'd4, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd4, 4'd7,  1'b0, 1'b0, 4'd3, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd5, 4'd5,  1'b0, 1'b1, 4'd2, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd6, 4'd4,  1'b0, 1'b1, 4'd1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 4'd0, 1'b1, 3'd7, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 4'd0, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 4'd0, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 4'd12, 1'b0, 1'b1, 4'd1, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 4'd1, 1'b1, 3'd0, 4'd13, 1'b1, 1'b1, 4'd0, 1'b1};
      tbl[16] = '{1'b0, 1'b1, 4'd1, 1'b0, 3'd1, 4'd13, 1'b1, 1'b1, 4'd0, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 4'd1, 1'b0, 3'd1, 4'd13, 1'b1, 1'b1, 4'd0, 1'b1};

      // Reset state, with a write request pending to prove w_en is gated.
      rst        = 1'b0;
      w_inc      = 1'b1;
      ovf_clr    = 1'b0;
      r_ptr_gray = 4'd0;
      @(negedge w_clk);
      @(negedge w_clk);
      chk("rst_w_en",   int'(w_en),        0);
      chk("rst_gray",   int'(w_ptr_gray),  0);
      chk("rst_full",   int'(full),        0);
      chk("rst_af",     int'(almost_full), 0);
      chk("rst_free",   int'(free_cnt),    8);
      chk("rst_ovf",    int'(overflow),    0);
      w_inc = 1'b0;
      rst   = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge w_clk);
         w_inc      = tbl[i].inc;
         ovf_clr    = tbl[i].clr;
         r_ptr_gray = tbl[i].rg;
         #1;
         chk($sformatf("v%0d_w_en", i),  int'(w_en),   int'(tbl[i].en));
         chk($sformatf("v%0d_w_addr", i), int'(w_addr), int'(tbl[i].addr));
         @(posedge w_clk);
         #1;
         chk($sformatf("v%0d_gray", i), int'(w_ptr_gray),  int'(tbl[i].gray));
         chk($sformatf("v%0d_full", i), int'(full),        int'(tbl[i].full));
         chk($sformatf("v%0d_af", i),   int'(almost_full), int'(tbl[i].af));
         chk($sformatf("v%0d_free", i), int'(free_cnt),    int'(tbl[i].free));
         chk($sformatf("v%0d_ovf", i),  int'(overflow),    int'(tbl[i].ovf));
      end

      // Asynchronous reset mid-cycle while full with overflow set.
      @(negedge w_clk);
      w_inc      = 1'b1;
      ovf_clr    = 1'b0;
      r_ptr_gray = 4'd0;
      rst        = 1'b0;
      #1;
      chk("mrst_w_en",  int'(w_en),        0);
      chk("mrst_addr",  int'(w_addr),      0);
      chk("mrst_gray",  int'(w_ptr_gray),  0);
      chk("mrst_full",  int'(full),        0);
      chk("mrst_af",    int'(almost_full), 0);
      chk("mrst_free",  int'(free_cnt),    8);
      chk("mrst_ovf",   int'(overflow),    0);
      w_inc = 1'b0;
      @(negedge w_clk);
      @(negedge w_clk);
      rst = 1'b1;

      // Streaming writes with the read pointer trailing by three writes, across two wraps.
      for (int i = 0; i < 40; i++) begin
         @(negedge w_clk);
         w_inc      = 1'b1;
         r_ptr_gray = (i >= 3) ? g4(i - 3) : 4'd0;
         #1;
         chk($sformatf("wrap%0d_w_en", i), int'(w_en),   1);
         chk($sformatf("wrap%0d_addr", i), int'(w_addr), i % 8);
         @(posedge w_clk);
         #1;
         chk($sformatf("wrap%0d_gray", i), int'(w_ptr_gray), int'(g4(i + 1)));
         chk($sformatf("wrap%0d_full", i), int'(full),       0);
      end
      @(negedge w_clk);
      w_inc = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of memory entries; power of two, >= 4.
REQ-002 SHALL have parameter AF_THRESH, default 2, almost_full asserts when free slots <= AF_THRESH.
REQ-003 SHALL derive localparam ADDR_WIDTH = $clog2(FIFO_DEPTH); pointers are ADDR_WIDTH+1 bits (PW).
REQ-004 w_clk  input  1  write-domain clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 w_inc  input  1  write request from producer.
REQ-007 ovf_clr  input  1  clears sticky overflow flag.
REQ-008 r_ptr_gray  input  PW  read pointer, Gray-coded, from read clock domain.
REQ-009 w_en  output  1  write strobe to FIFO memory.
REQ-010 w_addr  output  ADDR_WIDTH  write address to FIFO memory.
REQ-011 w_ptr_gray  output  PW  registered Gray write pointer, to read-domain synchronizer.
REQ-012 full  output  1  registered full flag.
REQ-013 almost_full  output  1  registered almost-full flag.
REQ-014 free_cnt  output  PW  registered free-slot count, 0..FIFO_DEPTH.
REQ-015 overflow  output  1  sticky: write attempted while full.

Function
REQ-016 w_en SHALL equal w_inc AND NOT full, combinationally.
REQ-017 Binary write pointer w_bin (PW bits) SHALL increment by 1 on each edge with w_en=1, wrapping 2^PW-1 -> 0.
REQ-018 w_addr SHALL equal w_bin[ADDR_WIDTH-1:0] (current, pre-increment value) so the write lands at the pre-increment slot.
REQ-019 w_ptr_gray SHALL be registered bin2gray(w_bin_next), i.e. always Gray of w_bin after the same edge; only one bit changes per increment.
REQ-020 r_ptr_gray SHALL pass through a two-flop synchronizer (rq1, rq2) in w_clk; no other logic touches the raw input.
REQ-021 Registered free_cnt SHALL be FIFO_DEPTH - (w_bin_next - gray2bin(rq2)) modulo 2^PW.
REQ-022 Registered full SHALL be 1 iff w_ptr_gray_next equals rq2 with its two MSBs inverted; full SHALL always equal (free_cnt==0).
REQ-023 Registered almost_full SHALL be 1 iff free_cnt_next <= AF_THRESH; full implies almost_full.
REQ-024 Full assertion latency: full SHALL be 1 at the edge whose write consumes the last free slot (same edge w_bin reaches rbin+FIFO_DEPTH).
REQ-025 Full deassertion latency: a read-pointer change on r_ptr_gray SHALL be reflected in full/free_cnt exactly 3 w_clk edges later (2 sync + 1 flag register).
REQ-026 w_inc while full SHALL NOT move w_bin, SHALL NOT assert w_en, and SHALL set overflow at that edge.
REQ-027 overflow SHALL stay 1 until an edge with ovf_clr=1 and no new overflow event; simultaneous set and clear: set wins.
REQ-028 Pointer wrap (MSB toggle) SHALL not disturb full/free_cnt computation.

Reset
REQ-029 rst low SHALL asynchronously clear w_bin, w_ptr_gray, rq1, rq2, overflow, full, almost_full to 0 and set free_cnt to FIFO_DEPTH; almost_full=0 unless AF_THRESH >= FIFO_DEPTH.
REQ-030 Reset mid-write SHALL discard the write-domain view; w_en SHALL be 0 while rst is low; release SHALL be synchronous to w_clk by the integrator.

Structure
REQ-031 Package ucie_fifo_pkg SHALL hold bin2gray and gray2bin functions (parameterised by width) shared with the read-side controller.
REQ-032 The two-flop synchronizer SHALL be a separate sub-module ptr_sync_2ff (parameter WIDTH, ports w_clk, rst, d, q), reused on the read side.

Verification (FIFO_DEPTH=8, AF_THRESH=2, r_ptr_gray held 0 unless stated)
REQ-033 Reset: rst=0 mid-stream -> immediately w_bin=0, w_ptr_gray=0, full=0, free_cnt=8, overflow=0, w_en=0.
REQ-034 Fill: 8 consecutive w_inc -> w_addr 0..7, w_ptr_gray 1,3,2,6,7,5,4,12; almost_full after 6th write, full after 8th, free_cnt=0.
REQ-035 Overflow: 9th w_inc while full -> w_en=0, w_bin unchanged at 8, overflow=1; ovf_clr pulse -> overflow=0; ovf_clr with concurrent w_inc while full -> overflow stays 1.
REQ-036 Drain latency: full, then r_ptr_gray driven to 1 -> full=1 for 2 more edges, 0 at 3rd edge, free_cnt=1, almost_full=1.
REQ-037 Wrap: stream 40 writes with r_ptr_gray tracking w_ptr_gray (lag 3) -> never full, w_addr wraps 7->0, w_ptr_gray Gray sequence passes 8 (bin) -> 12 and 15 -> 0 correctly.
REQ-038 Simultaneous: w_inc on the edge full deasserts -> write accepted that edge, full reasserts next edge.
